string_char_sequencer: RTL and testbench
========================================

STRING_CHAR_SEQUENCER -- requirements
Module: string_char_sequencer

Interface
REQ-001 Parameter NCHARS, default 11: maximum string length in characters.
REQ-002 Parameter CHAR_W, default 8: character width in bits.
REQ-003 Parameter LEN_W, default $clog2(NCHARS+1): width of length fields.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req0_valid  in  1  requester 0 offers a string.
REQ-008 req0_ready  out  1  requester 0 string accepted this cycle when valid&ready.
REQ-009 req0_str  in  NCHARS*CHAR_W  packed string, right-justified: first char most significant of the used bits, last char in bits [CHAR_W-1:0].
REQ-010 req0_len  in  LEN_W  number of characters used.
REQ-011 req1_valid, req1_ready, req1_str, req1_len  same as requester 0, for requester 1.
REQ-012 char_valid  out  1  char_data holds a character.
REQ-013 char_ready  in  1  sink accepts the character when valid&ready.
REQ-014 char_data  out  CHAR_W  current character.
REQ-015 char_last  out  1  current character is the last of its string.
REQ-016 char_src  out  1  requester index owning current character.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States: IDLE, SEND; at most one string in flight.
REQ-019 IDLE: ready is asserted only to the granted requester, combinationally from valid; the other requester's ready is 0.
REQ-020 Grant when both requesters are valid: round-robin; the requester not served last wins. When only one is valid, it wins.
REQ-021 Acceptance in cycle T captures str, effective length and source into internal registers and updates the round-robin pointer.
REQ-022 Effective length: len clamped to NCHARS; len values above NCHARS are not an error.
REQ-023 Effective length 0: accepted, no character emitted, state stays IDLE, pointer still updated.
REQ-024 Effective length L>=1: enter SEND; char_valid=1 from cycle T+1.
REQ-025 Character k (0..L-1) = captured bits [(L-1-k)*CHAR_W +: CHAR_W].
REQ-026 char_last=1 exactly for k=L-1.
REQ-027 char_data, char_last and char_src are held stable while char_valid&!char_ready; char_valid never drops without a handshake.
REQ-028 Each handshake advances k by one; the handshake on k=L-1 returns to IDLE with char_valid=0 the next cycle.
REQ-029 req*_ready=0 throughout SEND, so there is a one-cycle minimum gap between strings; changes on request inputs during SEND have no effect.
REQ-030 Throughput in SEND: one character per cycle when char_ready is held high.

Reset
REQ-031 Assertion of rst_n=0 immediately forces state IDLE, char_valid=0, char_data=0, char_last=0, char_src=0, busy=0, character index 0, and round-robin pointer = "1 served last", so requester 0 wins first.
REQ-032 Reset mid-string discards the string with no completion signalled; after release, the block behaves as after power-up.
REQ-033 req*_ready=0 while rst_n=0.

Structure
REQ-034 Shared package string_seq_pkg holds the state enum (IDLE, SEND) and the length-width helper function.
REQ-035 Round-robin grant logic is one sub-module, string_seq_rr_arb (2 requesters, pointer register, grant vector out).
REQ-036 Character selection is an indexed part-select from the captured register; no per-character register array.

Verification
REQ-037 req0 str="Hello World", len=11, char_ready=1 -> chars H,e,l,l,o,' ',W,o,r,l,d on 11 consecutive cycles starting T+1; char_last only on 'd'; char_src=0.
REQ-038 req0 and req1 both valid with "1"/len 1 and "22"/len 2 -> req0 served first ('1', last=1), one idle cycle, then req1 serves '2','2' (src=1); repeated continuous requests alternate 0,1,0,1.
REQ-039 Backpressure: "22" with char_ready low for 3 cycles after first valid -> char_data='2', last=0 held stable for all 3 cycles; then completes normally.
REQ-040 req1 len=0 -> req1_ready pulses, no char_valid, busy stays 0; next simultaneous request grants req0.
REQ-041 req0 len=15 with NCHARS=11 -> exactly 11 chars emitted, last = bits [7:0].
REQ-042 rst_n low during the 5th character of "Hello World" -> outputs zero immediately; after release, a new req1 string is emitted from its first character.

Source files
------------

// File: rtl/string_seq_pkg.sv
// Shared types and helpers for the string character sequencer.
//   seq_state_e : sequencer FSM state (IDLE, SEND)
//   len_width() : width needed to hold a length of 0..nchars
package string_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_e;

  function automatic int len_width(input int nchars);
    return $clog2(nchars + 1);
  endfunction

endpackage

// File: rtl/string_seq_rr_arb.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : requests (already qualified by the caller)
//   update     : a grant was taken this cycle; remember who was served
//   gnt[1:0]   : one-hot grant (0 when nobody requests)
// The pointer resets to "requester 1 served last", so requester 0 wins the
// first contended round.
module string_seq_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    else              gnt = req;
    last_d = last_q;
    if (update) last_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/string_char_sequencer.sv
// Accepts whole strings from two requesters and streams them out one
// character per handshake, first character first.
//   clk, rst_n            : clock, async active-low reset
//   reqN_valid/ready      : string offer / acceptance (N = 0, 1)
//   reqN_str              : right-justified packed string
//   reqN_len              : characters used (clamped to NCHARS)
//   char_valid/ready      : character stream handshake
//   char_data/last/src    : character, end-of-string flag, owning requester
//   busy                  : a string is being sent
module string_char_sequencer
  import string_seq_pkg::*;
#(
  parameter int NCHARS = 11,
  parameter int CHAR_W = 8,
  parameter int LEN_W  = len_width(NCHARS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [NCHARS*CHAR_W-1:0] req0_str,
  input  logic [LEN_W-1:0]         req0_len,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [NCHARS*CHAR_W-1:0] req1_str,
  input  logic [LEN_W-1:0]         req1_len,
  output logic                     char_valid,
  input  logic                     char_ready,
  output logic [CHAR_W-1:0]        char_data,
  output logic                     char_last,
  output logic                     char_src,
  output logic                     busy
);

  localparam int               STR_W   = NCHARS * CHAR_W;
  localparam int               OFF_W   = $clog2(STR_W);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NCHARS);

  seq_state_e        state_q, state_d;
  logic [STR_W-1:0]  str_q, str_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              src_q, src_d;

  logic [1:0]        gnt;
  logic              accept;
  logic [STR_W-1:0]  in_str;
  logic [LEN_W-1:0]  in_len, eff_len;
  logic [LEN_W-1:0]  sel_idx;
  logic [OFF_W-1:0]  sel_off;
  logic              in_send;

  string_seq_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (accept),
    .gnt    (gnt)
  );

  // Grant only reaches a requester while idle and out of reset; gnt is
  // already qualified by valid, so ready alone means a handshake.
  assign req0_ready = rst_n && (state_q == IDLE) && gnt[0];
  assign req1_ready = rst_n && (state_q == IDLE) && gnt[1];
  assign accept     = req0_ready | req1_ready;

  assign in_str  = gnt[1] ? req1_str : req0_str;
  assign in_len  = gnt[1] ? req1_len : req0_len;
  assign eff_len = (in_len > MAX_LEN) ? MAX_LEN : in_len;

  // Character k sits (L-1-k) characters up from the bottom of the string.
  assign in_send = (state_q == SEND);
  assign sel_idx = len_q - idx_q - LEN_W'(1);
  assign sel_off = OFF_W'(sel_idx) * OFF_W'(CHAR_W);

  // Outputs decode straight from registers, so they are stable while stalled.
  assign char_valid = in_send;
  assign busy       = in_send;
  assign char_last  = in_send && (idx_q == len_q - LEN_W'(1));
  assign char_data  = in_send ? str_q[sel_off +: CHAR_W] : '0;
  assign char_src   = src_q;

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    len_d   = len_q;
    idx_d   = idx_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          str_d = in_str;
          len_d = eff_len;
          src_d = gnt[1];
          idx_d = '0;
          // Zero-length strings are consumed without producing output.
          if (eff_len != '0) state_d = SEND;
        end
      end
      SEND: begin
        if (char_ready) begin
          if (char_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      str_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_string_char_sequencer.sv
// Directed bench for string_char_sequencer (default NCHARS=11, CHAR_W=8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_string_char_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [87:0] req0_str, req1_str;
  logic [3:0]  req0_len, req1_len;
  logic        char_valid, char_ready, char_last, char_src, busy;
  logic [7:0]  char_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  string_char_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_str   (req0_str),
    .req0_len   (req0_len),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_str   (req1_str),
    .req1_len   (req1_len),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_last  (char_last),
    .char_src   (char_src),
    .busy       (busy)
  );

  typedef struct {
    logic        src;
    logic [87:0] str;
    logic [3:0]  len;
    logic [87:0] exp;  // expected characters, right-justified
    int          n;    // expected character count
  } vec_t;

  vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one string from a single requester with the sink always ready and
  // check the emitted stream. Entered and left with the DUT idle.
  task automatic run_xfer(input logic src, input logic [87:0] str, input logic [3:0] len,
                          input logic [87:0] exp, input int n);
    logic [7:0] e;
    if (src) begin req1_valid = 1'b1; req1_str = str; req1_len = len; end
    else     begin req0_valid = 1'b1; req0_str = str; req0_len = len; end
    char_ready = 1'b1;
    #1;
    chk1("grant_ready", src ? req1_ready : req0_ready, 1'b1);
    chk1("other_ready", src ? req0_ready : req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      e = 8'(exp >> ((n - 1 - k) * 8));
      chk1("char_valid", char_valid, 1'b1);
      chk8("char_data", char_data, e);
      chk1("char_last", char_last, k == n - 1);
      chk1("char_src", char_src, src);
      tick();
    end
    chk1("end_valid", char_valid, 1'b0);
    chk1("end_busy", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, "Hello World", 4'd11, "Hello World", 11};
    vecs[1] = '{1'b1, "Hello World", 4'd3,  "rld",         3};
    vecs[2] = '{1'b0, "Hello World", 4'd15, "Hello World", 11};
    vecs[3] = '{1'b1, "AB",          4'd1,  "B",           1};
    vecs[4] = '{1'b0, "XYZ",         4'd0,  "",            0};

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_str = '0; req1_str = '0; req0_len = '0; req1_len = '0;
    char_ready = 1'b1;

    // Reset state, with both requesters pushing.
    #3;
    chk1("rst_valid", char_valid, 1'b0);
    chk8("rst_data", char_data, 8'h00);
    chk1("rst_last", char_last, 1'b0);
    chk1("rst_src", char_src, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Contended requests held continuously: grants alternate 0,1,0,1,
    // with an idle cycle between strings and ready low during SEND.
    req0_str = "1";  req0_len = 4'd1;
    req1_str = "22"; req1_len = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      logic w;
      int   n;
      w = g[0];
      n = w ? 2 : 1;
      chk1("rr_idle_valid", char_valid, 1'b0);
      chk1("rr_ready0", req0_ready, w == 1'b0);
      chk1("rr_ready1", req1_ready, w == 1'b1);
      tick();
      for (int k = 0; k < n; k++) begin
        chk1("rr_send_ready0", req0_ready, 1'b0);
        chk1("rr_send_ready1", req1_ready, 1'b0);
        chk8("rr_data", char_data, w ? 8'h32 : 8'h31);
        chk1("rr_src", char_src, w);
        chk1("rr_last", char_last, k == n - 1);
        if (g == 3 && k == n - 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        tick();
      end
    end

    // Table of single-requester strings.
    for (int i = 0; i < 5; i++)
      run_xfer(vecs[i].src, vecs[i].str, vecs[i].len, vecs[i].exp, vecs[i].n);

    // Zero-length on req1 still moves the pointer, so req0 wins next.
    run_xfer(1'b1, "AB", 4'd0, "", 0);
    req0_str = "1";  req0_len = 4'd1;
    req1_str = "22"; req1_len = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("len0_next_ready0", req0_ready, 1'b1);
    chk1("len0_next_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk8("len0_next_data", char_data, 8'h31);
    chk1("len0_next_src", char_src, 1'b0);
    tick();
    chk1("len0_next_done", char_valid, 1'b0);

    // Backpressure: first character held for three stalled cycles.
    req0_valid = 1'b1; req0_str = "22"; req0_len = 4'd2;
    #1;
    tick();
    req0_valid = 1'b0;
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("bp_valid", char_valid, 1'b1);
      chk8("bp_data", char_data, 8'h32);
      chk1("bp_last", char_last, 1'b0);
      tick();
    end
    char_ready = 1'b1;
    chk8("bp_rel_data", char_data, 8'h32);
    chk1("bp_rel_last", char_last, 1'b0);
    tick();
    chk8("bp_second_data", char_data, 8'h32);
    chk1("bp_second_last", char_last, 1'b1);
    tick();
    chk1("bp_done", char_valid, 1'b0);

    // Reset during the 5th character of "Hello World".
    req0_valid = 1'b1; req0_str = "Hello World"; req0_len = 4'd11;
    #1;
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    chk8("mid_5th_char", char_data, "o");
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", char_valid, 1'b0);
    chk8("mid_rst_data", char_data, 8'h00);
    chk1("mid_rst_last", char_last, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    req1_valid = 1'b1;
    #1;
    chk1("mid_rst_ready1", req1_ready, 1'b0);
    req1_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    // Pointer is back to its reset value: req0 would win a contended round.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("post_rst_ready0", req0_ready, 1'b1);
    chk1("post_rst_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    run_xfer(1'b1, "AB", 4'd2, "AB", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
